// File: rtl/rv_pkg.sv
// Encodings shared by the RV32I multi-cycle sequencer and the instruction decoder:
// opcode classes, sequencer states, trap causes, ALU selects and the legality check.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_BRANCH,
    ST_TRAP
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1001;

  function automatic logic instr_legal(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    logic legal;
    legal = 1'b0;
    case (opcode)
      OPC_OP:     legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      OPC_OP_IMM: legal = 1'b1;
      OPC_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv_branch_target.sv
// B-type immediate extraction and next-PC selection for a resolved branch;
// flags a taken target that is not 4-byte aligned.
module rv_branch_target #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [12:0]     imm13;
  logic [XLEN-1:0] imm;
  logic            unused_instr_bits;

  assign imm13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm   = {{(XLEN-13){imm13[12]}}, imm13};

  // Both sums wrap modulo 2^XLEN by construction.
  assign target     = taken ? (pc + imm) : (pc + XLEN'(4));
  assign misaligned = taken & target[1];

  assign unused_instr_bits = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle sequencer: req/ack fetch into the instruction register, legality
// check, execute/writeback/branch sequencing, PC ownership and sticky trap reporting.
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_q,
  input  logic            dec_reg_write,
  input  logic [3:0]      dec_alucontrol,
  output logic [3:0]      alu_op,
  output logic            alu_en,
  input  logic            branch_cond,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  localparam logic [7:0]      TIMEOUT_LIMIT = 8'(FETCH_TIMEOUT);
  localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            taken_q, taken_d;
  logic [1:0]      cause_q, cause_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;

  logic [XLEN-1:0] br_target;
  logic            br_misaligned;
  logic            is_branch;
  logic            legal;

  assign is_branch = (instr_q[6:0] == OPC_BRANCH);
  assign legal     = instr_legal(instr_q[6:0], instr_q[14:12], instr_q[31:25]);
  assign cnt_inc   = cnt_q + 8'd1;

  rv_branch_target #(
    .XLEN(XLEN)
  ) u_branch_target (
    .pc        (pc_q),
    .instr     (instr_q),
    .taken     (taken_q),
    .target    (br_target),
    .misaligned(br_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= INSTR_NOP;
      alu_op_q <= ALU_ADD;
      taken_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      alu_op_q <= alu_op_d;
      taken_q  <= taken_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    alu_op_d = alu_op_q;
    taken_d  = taken_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack on the cycle the counter would hit the limit still wins.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_LIMIT) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_FETCH_TO;
          end
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          alu_op_d = dec_alucontrol;
          state_d  = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        alu_en  = 1'b1;
        taken_d = is_branch & branch_cond;
        state_d = is_branch ? ST_BRANCH : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we   = dec_reg_write & (instr_q[11:7] != 5'd0);
        retire  = 1'b1;
        pc_d    = pc_q + PC_STEP;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_BRANCH: begin
        if (br_misaligned) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MISALIGN;
        end else begin
          retire  = 1'b1;
          pc_d    = br_target;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) cnt_d = '0;
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign alu_op     = alu_op_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed programs for rv_multicycle_ctrl with a req/ack memory responder and a
// scoreboard monitor that checks every fetch, retire and trap against queued expectations.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;
  import rv_pkg::*;

  localparam int XLEN  = 32;
  localparam int FT    = 16;
  localparam int NOACK = -1;

  logic        clk, rst_n, run;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instr_q, pc;
  logic        dec_reg_write, alu_en, branch_cond, rf_we, retire, trap;
  logic [3:0]  dec_alucontrol, alu_op;
  logic [1:0]  trap_cause;

  typedef struct {
    bit          is_trap;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        rf_we;
    logic [3:0]  alu_op;
    logic [1:0]  cause;
    int          lat;
  } evt_t;

  evt_t        exp_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ill_vec [4];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ack_delay = 1;

  rv_multicycle_ctrl #(
    .XLEN(XLEN),
    .RESET_PC(32'h0000_0000),
    .FETCH_TIMEOUT(FT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_q       (instr_q),
    .dec_reg_write (dec_reg_write),
    .dec_alucontrol(dec_alucontrol),
    .alu_op        (alu_op),
    .alu_en        (alu_en),
    .branch_cond   (branch_cond),
    .rf_we         (rf_we),
    .pc            (pc),
    .retire        (retire),
    .trap          (trap),
    .trap_cause    (trap_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Stand-in for the external decoder.
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_alucontrol = ALU_ADD;
    if (instr_q[6:0] == OPC_BRANCH) begin
      dec_alucontrol = (instr_q[14:12] == 3'b001) ? ALU_NE : ALU_EQ;
    end else begin
      dec_reg_write = 1'b1;
      if (instr_q[6:0] == OPC_OP && instr_q[30]) dec_alucontrol = ALU_SUB;
    end
  end

  // Memory responder: acks in the ack_delay-th cycle of each request (0-based).
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (imem_req && rst_n) begin
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : INSTR_NOP;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=none", name, act);
  endtask

  function automatic void exp_retire(input logic [31:0] p, input logic [31:0] pn,
                                     input logic we, input logic [3:0] op);
    evt_t e;
    e.is_trap = 1'b0; e.pc = p; e.pc_next = pn; e.rf_we = we;
    e.alu_op = op; e.cause = CAUSE_NONE; e.lat = -1;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_trap(input logic [31:0] p, input logic [1:0] cause, input int lat);
    evt_t e;
    e.is_trap = 1'b1; e.pc = p; e.pc_next = p; e.rf_we = 1'b0;
    e.alu_op = ALU_ADD; e.cause = cause; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor.
  initial begin
    bit          prev_req, prev_trap, pend;
    logic [31:0] pend_pc;
    int          rise_cyc;
    evt_t        e;
    prev_req = 0; prev_trap = 0; pend = 0; pend_pc = 0; rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0; prev_trap = 0; pend = 0;
        continue;
      end
      if (pend) begin
        check("pc_after_retire", pc, pend_pc);
        pend = 0;
      end
      if (imem_req && !prev_req) begin
        rise_cyc = cyc;
        if (fetch_q.size() == 0) fail_now("unexpected_fetch", imem_addr);
        else check("fetch_addr", imem_addr, fetch_q.pop_front());
        $display("fetch addr=%h cyc=%0d", imem_addr, cyc);
      end
      if (rf_we && !retire) fail_now("rf_we_without_retire", pc);
      if (retire) begin
        $display("retire pc=%h rf_we=%0b alu_op=%h", pc, rf_we, alu_op);
        if (exp_q.size() == 0) fail_now("unexpected_retire", pc);
        else begin
          e = exp_q.pop_front();
          if (e.is_trap) fail_now("retire_where_trap_expected", pc);
          else begin
            check("retire_pc", pc, e.pc);
            check("rf_we", 32'(rf_we), 32'(e.rf_we));
            check("alu_op", 32'(alu_op), 32'(e.alu_op));
            pend = 1; pend_pc = e.pc_next;
          end
        end
      end
      if (trap && !prev_trap) begin
        $display("trap cause=%b pc=%h cyc=%0d", trap_cause, pc, cyc);
        if (exp_q.size() == 0) fail_now("unexpected_trap", 32'(trap_cause));
        else begin
          e = exp_q.pop_front();
          if (!e.is_trap) fail_now("trap_where_retire_expected", 32'(trap_cause));
          else begin
            check("trap_cause", 32'(trap_cause), 32'(e.cause));
            check("trap_pc", pc, e.pc);
            if (e.lat >= 0) check("trap_latency", 32'(cyc - rise_cyc), 32'(e.lat));
          end
        end
      end
      prev_req  = imem_req;
      prev_trap = trap;
    end
  end

  task automatic do_reset();
    check("leftover_events", 32'(exp_q.size()), 32'd0);
    check("leftover_fetches", 32'(fetch_q.size()), 32'd0);
    @(negedge clk);
    run = 1'b0; branch_cond = 1'b0; ack_delay = 1; rst_n = 1'b0;
    exp_q.delete(); fetch_q.delete(); mem.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs until the n-th EXECUTE, drops run there, and expects a stop in IDLE.
  task automatic run_exec(input int n, input string tag);
    int k = 0;
    int t = 0;
    run = 1'b1;
    while (k < n && t < 400) begin
      @(negedge clk);
      t++;
      if (alu_en) k++;
    end
    run = 1'b0;
    if (k < n) fail_now({tag, "_exec_timeout"}, 32'(k));
    repeat (4) @(negedge clk);
    check({tag, "_idle_req"}, 32'(imem_req), 32'd0);
  endtask

  task automatic run_trap(input string tag);
    int t = 0;
    run = 1'b1;
    while (!trap && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!trap) fail_now({tag, "_no_trap"}, 32'(t));
    repeat (6) @(negedge clk);
    check({tag, "_trap_held"}, 32'(trap), 32'd1);
    check({tag, "_req_after_trap"}, 32'(imem_req), 32'd0);
    run = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; run = 1'b0; branch_cond = 1'b0;
    ill_vec[0] = 32'h0000_007F;
    ill_vec[1] = 32'h0200_0033;
    ill_vec[2] = 32'h0020_A463;
    ill_vec[3] = 32'h0020_B463;
    #1;
    check("inrst_req", 32'(imem_req), 32'd0);

    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr_q, 32'h0000_0013);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_trap", 32'({trap, trap_cause}), 32'd0);
    check("rst_strobes", 32'({imem_req, alu_en, rf_we, retire}), 32'd0);

    // addi x1,x0,5 then addi x0,x0,0; run dropped in the second EXECUTE.
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h0000_0013;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
    exp_retire(32'h0, 32'h4, 1'b1, ALU_ADD);
    exp_retire(32'h4, 32'h8, 1'b0, ALU_ADD);
    run_exec(2, "addi_nop");

    // beq +8 at 0x10, taken then not taken.
    for (int c = 1; c >= 0; c--) begin
      do_reset();
      branch_cond = (c == 1);
      for (int a = 0; a < 16; a += 4) begin
        mem[32'(a)] = INSTR_NOP;
        fetch_q.push_back(32'(a));
        exp_retire(32'(a), 32'(a + 4), 1'b0, ALU_ADD);
      end
      mem[32'h10] = 32'h0020_8463;
      fetch_q.push_back(32'h10);
      exp_retire(32'h10, (c == 1) ? 32'h18 : 32'h14, 1'b0, ALU_EQ);
      run_exec(5, "beq");
    end

    // beq -4 from 0 wraps to the top of the address space.
    do_reset();
    branch_cond = 1'b1;
    mem[32'h0] = 32'hFE20_8EE3;
    fetch_q.push_back(32'h0);
    exp_retire(32'h0, 32'hFFFF_FFFC, 1'b0, ALU_EQ);
    run_exec(1, "beq_wrap");

    // add x3,x1,x2 then sub x0,x1,x2.
    do_reset();
    mem[32'h0] = 32'h0020_81B3;
    mem[32'h4] = 32'h4020_8033;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
    exp_retire(32'h0, 32'h4, 1'b1, ALU_ADD);
    exp_retire(32'h4, 32'h8, 1'b0, ALU_SUB);
    run_exec(2, "op_add_sub");

    // beq +2 at 0x4: taken traps with pc frozen, not taken retires.
    do_reset();
    branch_cond = 1'b1;
    mem[32'h0] = INSTR_NOP;
    mem[32'h4] = 32'h0020_8163;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
    exp_retire(32'h0, 32'h4, 1'b0, ALU_ADD);
    exp_trap(32'h4, CAUSE_MISALIGN, -1);
    run_trap("br_misalign");

    do_reset();
    mem[32'h0] = INSTR_NOP;
    mem[32'h4] = 32'h0020_8163;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
    exp_retire(32'h0, 32'h4, 1'b0, ALU_ADD);
    exp_retire(32'h4, 32'h8, 1'b0, ALU_EQ);
    run_exec(2, "br_misalign_nt");

    // Illegal encodings at 0x4.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      mem[32'h0] = INSTR_NOP;
      mem[32'h4] = ill_vec[i];
      fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
      exp_retire(32'h0, 32'h4, 1'b0, ALU_ADD);
      exp_trap(32'h4, CAUSE_ILLEGAL, -1);
      run_trap("illegal");
    end
    do_reset();
    check("trap_cleared", 32'({trap, trap_cause}), 32'd0);
    check("trap_cleared_pc", pc, 32'h0);

    // Ack withheld: timeout trap exactly FT cycles after req rises.
    ack_delay = NOACK;
    fetch_q.push_back(32'h0);
    exp_trap(32'h0, CAUSE_FETCH_TO, FT);
    run_trap("fetch_timeout");

    // Ack on the limit cycle wins over the timeout.
    do_reset();
    ack_delay = FT - 1;
    mem[32'h0] = 32'h0050_0093;
    fetch_q.push_back(32'h0);
    exp_retire(32'h0, 32'h4, 1'b1, ALU_ADD);
    run_exec(1, "ack_at_limit");
    check("ack_at_limit_no_trap", 32'(trap), 32'd0);

    // Reset pulse in the middle of the fetch at 0x4.
    do_reset();
    mem[32'h0] = 32'h0050_0093;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
    exp_retire(32'h0, 32'h4, 1'b1, ALU_ADD);
    run = 1'b1;
    t = 0;
    while (!retire && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!retire) fail_now("midfetch_no_retire", 32'(t));
    ack_delay = NOACK;
    repeat (3) @(negedge clk);
    check("midfetch_req", 32'(imem_req), 32'd1);
    check("midfetch_addr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_pc", pc, 32'h0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_req", 32'(imem_req), 32'd0);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
